// File: rtl/vjtag_uart_pkg.sv
// Shared definitions for the virtual-JTAG UART bridge.
//   - IR instruction codes (low two bits of the virtual IR)
//   - scan FSM state encoding
//   - bit positions of the fields in the STATUS capture word
package vjtag_uart_pkg;

    localparam logic [1:0] IR_BYPASS = 2'b00;
    localparam logic [1:0] IR_WRITE  = 2'b01;
    localparam logic [1:0] IR_READ   = 2'b10;
    localparam logic [1:0] IR_STATUS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_SHIFT = 2'd2
    } vjtag_state_e;

    // STATUS word layout, LSB first on tdo: frame_err, rx_overflow, rx_level
    localparam int STAT_FERR_BIT = 0;
    localparam int STAT_OVF_BIT  = 1;
    localparam int STAT_LVL_LSB  = 2;

endpackage

// File: rtl/vjtag_uart_bridge_fifo.sv
// vjtag_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointers/count only)
//   push, wdata  write request and data; accepted when not full or when a
//                pop happens on the same edge
//   pop          read request; ignored when empty
//   rdata        head word, forced to 0 while empty
//   full, empty  occupancy flags
//   level        number of stored words (DEPTH when full)
module vjtag_sync_fifo
    import vjtag_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign level   = cnt_q;
    assign do_pop  = pop && !empty;
    // When full, a same-edge pop frees the slot the write pointer points at.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vjtag_uart_bridge.sv
// vjtag_uart_bridge: virtual-JTAG <-> word stream bridge in the tck domain.
// Host WRITE scans are deserialised into DATA_W-bit words and queued in an RX
// FIFO; READ scans serialise a TX word (valid flag first) back to the host.
// Optional feature macro: VJTAG_STATUS_EN (STATUS capture/clear of flags);
// when undefined, the STATUS instruction acts as BYPASS.
// Ports:
//   tck, rst_n                 clock, synchronous active-low reset
//   ir_in                      virtual IR (low two bits decoded)
//   tdi / tdo                  JTAG data in / out (tdo = sr[0])
//   v_cdr, v_sdr, v_udr        virtual capture/shift/update-DR strobes
//   rx_data/rx_valid/rx_ready  RX FIFO head, valid/ready handshake
//   tx_data/tx_valid/tx_ready  TX word offer; tx_ready pulses on consumption
//   rx_level                   RX FIFO occupancy
//   rx_overflow, frame_err     sticky error flags
module vjtag_uart_bridge
    import vjtag_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int IR_W   = 2
) (
    input  logic                       tck,
    input  logic                       rst_n,
    input  logic [IR_W-1:0]            ir_in,
    input  logic                       tdi,
    output logic                       tdo,
    input  logic                       v_cdr,
    input  logic                       v_sdr,
    input  logic                       v_udr,
    output logic [DATA_W-1:0]          rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    input  logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] rx_level,
    output logic                       rx_overflow,
    output logic                       frame_err
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_W);

    vjtag_state_e       state_q, state_d;
    logic [DATA_W:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ovf_q, ovf_d;
    logic               ferr_q, ferr_d;

    logic [1:0]         ir_code;
    logic               commit, push_req, ovf_set, ferr_set, stat_clr;
    logic               fifo_full, fifo_empty;

    assign ir_code = ir_in[1:0];

    // Scan FSM: a capture strobe always restarts the scan.
    always_comb begin
        state_d = state_q;
        if (v_cdr) begin
            state_d = ST_CAPT;
        end else begin
            case (state_q)
                ST_CAPT: begin
                    if (v_sdr)      state_d = ST_SHIFT;
                    else if (v_udr) state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (v_udr) state_d = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

`ifdef VJTAG_STATUS_EN
    logic [DATA_W:0] status_w;

    always_comb begin
        status_w = '0;
        status_w[STAT_FERR_BIT]              = ferr_q;
        status_w[STAT_OVF_BIT]               = ovf_q;
        status_w[STAT_LVL_LSB +: LVL_W]      = rx_level;
    end

    assign stat_clr = v_udr && (ir_code == IR_STATUS);
`else
    assign stat_clr = 1'b0;
`endif

    // Shift register: capture has priority over shift if both strobes appear.
    always_comb begin
        sr_d = sr_q;
        if (v_cdr) begin
            sr_d = '0;
            if (ir_code == IR_READ && tx_valid) sr_d = {tx_data, 1'b1};
`ifdef VJTAG_STATUS_EN
            if (ir_code == IR_STATUS) sr_d = status_w;
`endif
        end else if (v_sdr) begin
            sr_d = {tdi, sr_q[DATA_W:1]};
        end
    end

    // Bit counter saturates one past a full word so over-long frames stay detectable.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (v_cdr)                               bit_cnt_d = '0;
        else if (v_sdr && bit_cnt_q != CNT_MAX)  bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    assign commit   = v_udr && (ir_code == IR_WRITE);
    assign push_req = commit && (bit_cnt_q == CNT_WORD);
    assign ferr_set = commit && (bit_cnt_q != CNT_WORD);
    assign ovf_set  = push_req && fifo_full && !(rx_ready && !fifo_empty);

    // Setting a flag wins over a simultaneous STATUS clear.
    always_comb begin
        ovf_d  = ovf_q;
        ferr_d = ferr_q;
        if (stat_clr) begin
            ovf_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovf_set)  ovf_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
    end

    always_ff @(posedge tck) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
        end
    end

    vjtag_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_rx_fifo (
        .clk   (tck),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (sr_q[DATA_W:1]),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (rx_level)
    );

    assign rx_valid    = !fifo_empty;
    assign tdo         = sr_q[0];
    assign rx_overflow = ovf_q;
    assign frame_err   = ferr_q;
    // Consumed on the capture cycle itself, whether or not the host completes the scan.
    assign tx_ready    = rst_n && v_cdr && (ir_code == IR_READ) && tx_valid;

endmodule

// File: tb/tb_vjtag_uart_bridge.sv
module tb_vjtag_uart_bridge;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int IR_W   = 2;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    localparam logic [1:0] C_BYPASS = 2'b00;
    localparam logic [1:0] C_WRITE  = 2'b01;
    localparam logic [1:0] C_READ   = 2'b10;
    localparam logic [1:0] C_STATUS = 2'b11;

    logic              tck = 1'b0;
    logic              rst_n;
    logic [IR_W-1:0]   ir_in;
    logic              tdi;
    logic              tdo;
    logic              v_cdr, v_sdr, v_udr;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [LVL_W-1:0]  rx_level;
    logic              rx_overflow;
    logic              frame_err;

    vjtag_uart_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IR_W(IR_W)) dut (
        .tck(tck), .rst_n(rst_n), .ir_in(ir_in), .tdi(tdi), .tdo(tdo),
        .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_level(rx_level), .rx_overflow(rx_overflow), .frame_err(frame_err)
    );

    always #5 tck = ~tck;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: RX queue of words plus the two sticky flags.
    int rxq[$];
    bit m_ovf, m_ferr;

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          exp_level;
        int          exp_head;
        int          exp_ferr;
        int          exp_ovf;
    } wvec_t;

    wvec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir_in = '0; tdi = 1'b0;
        v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0;
        rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        rxq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic scan_write(input logic [15:0] w, input int nb, input bit udr_rdy);
        ir_in = C_WRITE; v_cdr = 1'b1; step(); v_cdr = 1'b0;
        for (int i = 0; i < nb; i++) begin
            v_sdr = 1'b1; tdi = w[i]; step();
        end
        v_sdr = 1'b0; v_udr = 1'b1; rx_ready = udr_rdy; step();
        v_udr = 1'b0; rx_ready = 1'b0;
    endtask

    task automatic m_write(input logic [15:0] w, input int nb, input bit rdy);
        bit popped;
        bit was_full;
        popped   = (rxq.size() > 0) && rdy;
        was_full = (rxq.size() == DEPTH);
        if (popped) void'(rxq.pop_front());
        if (nb == DATA_W) begin
            if (!was_full || popped) rxq.push_back(int'(w[7:0]));
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic pop_cycle();
        if (rxq.size() > 0) void'(rxq.pop_front());
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
    endtask

    task automatic read_scan(input bit vld, input logic [7:0] d);
        int ev;
        ev = vld ? ((int'(d) << 1) | 1) : 0;
        ir_in = C_READ; tx_valid = vld; tx_data = d; v_cdr = 1'b1;
        #1;
        chk("tx_ready_at_cdr", int'(tx_ready), int'(vld));
        step();
        v_cdr = 1'b0;
        #1;
        chk("tx_ready_after_cdr", int'(tx_ready), 0);
        tx_valid = 1'b0;
        for (int i = 0; i < DATA_W + 1; i++) begin
            chk($sformatf("read_tdo[%0d]", i), int'(tdo), (ev >> i) & 1);
            v_sdr = 1'b1; tdi = 1'($urandom_range(0, 1)); step();
        end
        v_sdr = 1'b0; v_udr = 1'b1; step(); v_udr = 1'b0;
    endtask

    task automatic status_scan(input int ev);
        ir_in = C_STATUS; v_cdr = 1'b1; step(); v_cdr = 1'b0;
        for (int i = 0; i < DATA_W + 1; i++) begin
            chk($sformatf("status_tdo[%0d]", i), int'(tdo), (ev >> i) & 1);
            v_sdr = 1'b1; tdi = 1'b0; step();
        end
        v_sdr = 1'b0; v_udr = 1'b1; step(); v_udr = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_level"}, int'(rx_level), rxq.size());
        chk({tag, "_valid"}, int'(rx_valid), int'(rxq.size() > 0));
        if (rxq.size() > 0) chk({tag, "_data"}, int'(rx_data), rxq[0]);
        chk({tag, "_ovf"}, int'(rx_overflow), int'(m_ovf));
        chk({tag, "_ferr"}, int'(frame_err), int'(m_ferr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          nb;
        int          op;
        int          ev;
        bit          rdy;
        int          nbs[5];

        tbl[0] = '{16'h00A5, 8, 1, 'hA5, 0, 0};
        tbl[1] = '{16'h003C, 7, 1, 'hA5, 1, 0};
        tbl[2] = '{16'h0011, 9, 1, 'hA5, 1, 0};
        tbl[3] = '{16'h0022, 8, 2, 'hA5, 1, 0};
        tbl[4] = '{16'h0033, 8, 3, 'hA5, 1, 0};
        tbl[5] = '{16'h0044, 8, 4, 'hA5, 1, 0};
        tbl[6] = '{16'h0055, 8, 4, 'hA5, 1, 1};
        nbs = '{7, 8, 8, 8, 9};

        // Reset state
        do_reset();
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_level", int'(rx_level), 0);
        chk("rst_tdo", int'(tdo), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_ovf", int'(rx_overflow), 0);
        chk("rst_ferr", int'(frame_err), 0);

        // Table-driven write scans, consumer stalled
        for (int k = 0; k < 7; k++) begin
            scan_write(tbl[k].word, tbl[k].nbits, 1'b0);
            chk($sformatf("tbl%0d_level", k), int'(rx_level), tbl[k].exp_level);
            chk($sformatf("tbl%0d_valid", k), int'(rx_valid), int'(tbl[k].exp_level != 0));
            chk($sformatf("tbl%0d_head", k), int'(rx_data), tbl[k].exp_head);
            chk($sformatf("tbl%0d_ferr", k), int'(frame_err), tbl[k].exp_ferr);
            chk($sformatf("tbl%0d_ovf", k), int'(rx_overflow), tbl[k].exp_ovf);
        end

        // Single word then pop
        do_reset();
        scan_write(16'h00A5, 8, 1'b0);
        chk("a5_valid", int'(rx_valid), 1);
        chk("a5_data", int'(rx_data), 'hA5);
        chk("a5_level", int'(rx_level), 1);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        chk("a5_pop_valid", int'(rx_valid), 0);
        chk("a5_pop_level", int'(rx_level), 0);

        // Overflow and drain order
        do_reset();
        for (int i = 1; i <= 5; i++) scan_write(16'(i), 8, 1'b0);
        chk("ovf_level", int'(rx_level), 4);
        chk("ovf_flag", int'(rx_overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d", i), int'(rx_data), i);
            rx_ready = 1'b1; step(); rx_ready = 1'b0;
        end
        chk("drain_empty", int'(rx_valid), 0);

        // Framing errors: short and long scans
        do_reset();
        scan_write(16'h005A, 7, 1'b0);
        chk("short_ferr", int'(frame_err), 1);
        chk("short_valid", int'(rx_valid), 0);
        do_reset();
        scan_write(16'h005A, 9, 1'b0);
        chk("long_ferr", int'(frame_err), 1);
        chk("long_valid", int'(rx_valid), 0);

        // READ with and without a TX word
        do_reset();
        read_scan(1'b1, 8'h3C);
        read_scan(1'b0, 8'h3C);

        // Push while full with a pop on the same edge
        do_reset();
        for (int i = 1; i <= 4; i++) scan_write(16'(i), 8, 1'b0);
        scan_write(16'h0099, 8, 1'b1);
        chk("fullpop_level", int'(rx_level), 4);
        chk("fullpop_ovf", int'(rx_overflow), 0);
        chk("fullpop_head", int'(rx_data), 2);
        for (int i = 0; i < 3; i++) begin rx_ready = 1'b1; step(); end
        rx_ready = 1'b0;
        chk("fullpop_tail", int'(rx_data), 'h99);

        // STATUS scan with level=3, overflow=1, frame_err=1
        do_reset();
        for (int i = 1; i <= 5; i++) scan_write(16'(i), 8, 1'b0);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        scan_write(16'h0000, 7, 1'b0);
        chk("stat_pre_level", int'(rx_level), 3);
`ifdef VJTAG_STATUS_EN
        status_scan(15);
        chk("stat_clr_ovf", int'(rx_overflow), 0);
        chk("stat_clr_ferr", int'(frame_err), 0);
`else
        status_scan(0);
        chk("stat_keep_ovf", int'(rx_overflow), 1);
        chk("stat_keep_ferr", int'(frame_err), 1);
`endif

        // Reset in the middle of a WRITE scan
        do_reset();
        scan_write(16'h00A5, 8, 1'b0);
        scan_write(16'h0000, 7, 1'b0);
        ir_in = C_WRITE; v_cdr = 1'b1; step(); v_cdr = 1'b0;
        for (int i = 0; i < 4; i++) begin v_sdr = 1'b1; tdi = 1'b1; step(); end
        rst_n = 1'b0; step();
        chk("midrst_valid", int'(rx_valid), 0);
        chk("midrst_tdo", int'(tdo), 0);
        chk("midrst_level", int'(rx_level), 0);
        chk("midrst_ovf", int'(rx_overflow), 0);
        chk("midrst_ferr", int'(frame_err), 0);
        v_sdr = 1'b0; rst_n = 1'b1;

        // Randomised operations against the queue model
        do_reset();
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                w   = 16'($urandom_range(0, 511));
                nb  = nbs[$urandom_range(0, 4)];
                rdy = 1'($urandom_range(0, 1));
                m_write(w, nb, rdy);
                scan_write(w, nb, rdy);
            end else if (op <= 6) begin
                pop_cycle();
            end else if (op == 7) begin
                read_scan(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end else begin
                ev = int'(m_ferr) | (int'(m_ovf) << 1) | (rxq.size() << 2);
`ifdef VJTAG_STATUS_EN
                status_scan(ev);
                m_ovf = 1'b0; m_ferr = 1'b0;
`else
                status_scan(0);
`endif
            end
            check_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Unused in stimulus other than as an IR code reference.
    logic [1:0] unused_bypass;
    assign unused_bypass = C_BYPASS;

endmodule
